// File: rtl/vec_norm_pkg.sv
// Shared types and helpers for the Q8.24 vector normaliser.
//   WIDTH_Q / FRAC_Q : word width and fractional bits of the Q8.24 format
//   q8_24_t          : signed Q8.24 scalar
//   vec3_t           : packed {x, y, z} direction vector
//   fx_mul           : signed Q8.24 x unsigned Q8.24 -> signed Q8.24 (truncating)
package vec_norm_pkg;

  localparam int WIDTH_Q = 32;
  localparam int FRAC_Q  = 24;

  typedef logic signed [WIDTH_Q-1:0] q8_24_t;

  typedef struct packed {
    q8_24_t x;
    q8_24_t y;
    q8_24_t z;
  } vec3_t;

  // The unsigned operand gets a zero MSB so the product stays signed. The
  // true product fits in 2*WIDTH_Q+1 bits, so the modular multiply is exact.
  function automatic q8_24_t fx_mul(input q8_24_t a, input logic [WIDTH_Q-1:0] b);
    logic [2*WIDTH_Q:0]        a_ext;
    logic [2*WIDTH_Q:0]        b_ext;
    logic signed [2*WIDTH_Q:0] prod;
    logic signed [2*WIDTH_Q:0] prod_sh;
    a_ext   = {{(WIDTH_Q+1){a[WIDTH_Q-1]}}, a};
    b_ext   = {{(WIDTH_Q+1){1'b0}}, b};
    prod    = a_ext * b_ext;
    prod_sh = prod >>> FRAC_Q;
    return prod_sh[WIDTH_Q-1:0];
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Synchronous FIFO holding vectors that wait for their inv_sqrt result.
//   clk, rst (async, active low)
//   push/din   : write one entry (ignored when full)
//   pop/dout   : dout shows the head combinationally; pop drops it (ignored when empty)
//   count      : registered occupancy, full = (count == DEPTH), empty = (count == 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module vec_fifo #(
  parameter int DW    = 96,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head must be visible in the same cycle the result returns, so the read
  // is combinational from the array.
  assign dout = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vec3_normalize.sv
// Normalises a signed Q8.24 3-vector using an external in-order inv_sqrt unit.
//   clk, rst (async, active low)
//   valid_in/in_ready, vx_in/vy_in/vz_in : input vector handshake
//   isq_valid, isq_x                     : squared length issued to inv_sqrt
//   isq_valid_out, isq_result            : 1/sqrt result returning from inv_sqrt
//   valid_out, nx/ny/nz, zero_vec        : normalised vector (single-cycle pulse)
//   err_underflow                        : sticky, a result arrived with nothing pending
// Optional macro VEC_NORM_ZERO_GUARD_EN: zero-length vectors produce 0,0,0 with
// zero_vec=1; without it zero_vec is tied low and the raw product is output.
module vec3_normalize
  import vec_norm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_Q,
  parameter int FRAC    = FRAC_Q,
  parameter int DEPTH   = 8,
  parameter int ISQ_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vx_in,
  input  logic [WIDTH-1:0] vy_in,
  input  logic [WIDTH-1:0] vz_in,
  output logic             isq_valid,
  output logic [WIDTH-1:0] isq_x,
  input  logic             isq_valid_out,
  input  logic [WIDTH-1:0] isq_result,
  output logic             valid_out,
  output logic [WIDTH-1:0] nx,
  output logic [WIDTH-1:0] ny,
  output logic [WIDTH-1:0] nz,
  output logic             zero_vec,
  output logic             err_underflow
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef VEC_NORM_ZERO_GUARD_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif
  localparam int DW = $bits(vec3_t) + ZW;

  // A shallower FIFO still works, it just throttles acceptance while results
  // are in flight; no extra logic is needed for that case.
  if (DEPTH < ISQ_LAT + 2) begin : g_depth_limits_rate
  end

  // ---------------- squared length ----------------
  logic [WIDTH-1:0] comp_in [3];
  logic [WIDTH-1:0] sq_sat  [3];

  assign comp_in[0] = vx_in;
  assign comp_in[1] = vy_in;
  assign comp_in[2] = vz_in;

  // A single square can already exceed WIDTH+2 bits after the shift, so each
  // one is clamped before the sum; the final saturation is then exact.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_square
      logic [2*WIDTH-1:0] comp_ext;
      logic [2*WIDTH-1:0] prod;
      logic [2*WIDTH-1:0] prod_sh;
      assign comp_ext   = {{WIDTH{comp_in[gi][WIDTH-1]}}, comp_in[gi]};
      assign prod       = comp_ext * comp_ext;
      // A square is never negative, so a logical shift equals the arithmetic one.
      assign prod_sh    = prod >> FRAC;
      assign sq_sat[gi] = (|prod_sh[2*WIDTH-1:WIDTH]) ? '1 : prod_sh[WIDTH-1:0];
    end
  endgenerate

  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] sum_sat;

  assign sum     = {2'b00, sq_sat[0]} + {2'b00, sq_sat[1]} + {2'b00, sq_sat[2]};
  assign sum_sat = (|sum[WIDTH+1:WIDTH]) ? '1 : sum[WIDTH-1:0];

  // ---------------- FIFO of pending vectors ----------------
  logic          accept;
  logic          pop;
  vec3_t         vec_in;
  vec3_t         head_vec;
  logic [DW-1:0] fifo_din;
  logic [DW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ready = !fifo_full;
  assign accept   = valid_in && in_ready;
  assign pop      = isq_valid_out && !fifo_empty;

  assign vec_in.x = vx_in;
  assign vec_in.y = vy_in;
  assign vec_in.z = vz_in;

`ifdef VEC_NORM_ZERO_GUARD_EN
  logic sum_zero;
  logic head_zero;
  assign sum_zero  = (sum == '0);
  assign fifo_din  = {vec_in, sum_zero};
  assign head_vec  = fifo_dout[DW-1:1];
  assign head_zero = fifo_dout[0];
`else
  assign fifo_din  = vec_in;
  assign head_vec  = fifo_dout;
`endif

  vec_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- issue to inv_sqrt ----------------
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_sum_reg;
  logic             isq_valid_reg;
  logic [WIDTH-1:0] isq_x_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sum_reg    <= '0;
      isq_valid_reg <= 1'b0;
      isq_x_reg     <= '0;
    end else begin
      s1_valid_reg  <= accept;
      if (accept) s1_sum_reg <= sum_sat;
      isq_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) isq_x_reg <= s1_sum_reg;
    end
  end

  assign isq_valid = isq_valid_reg;
  assign isq_x     = isq_x_reg;

  // ---------------- output stage ----------------
  logic             valid_out_reg;
  logic [WIDTH-1:0] nx_reg;
  logic [WIDTH-1:0] ny_reg;
  logic [WIDTH-1:0] nz_reg;
  logic             err_underflow_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out_reg     <= 1'b0;
      nx_reg            <= '0;
      ny_reg            <= '0;
      nz_reg            <= '0;
      err_underflow_reg <= 1'b0;
    end else begin
      valid_out_reg <= pop;
      // A result with nothing pending means the inv_sqrt stream is out of
      // step with ours; flag it and keep the FIFO untouched.
      if (isq_valid_out && (fifo_count == '0)) err_underflow_reg <= 1'b1;
      if (pop) begin
`ifdef VEC_NORM_ZERO_GUARD_EN
        if (head_zero) begin
          nx_reg <= '0;
          ny_reg <= '0;
          nz_reg <= '0;
        end else begin
          nx_reg <= fx_mul(head_vec.x, isq_result);
          ny_reg <= fx_mul(head_vec.y, isq_result);
          nz_reg <= fx_mul(head_vec.z, isq_result);
        end
`else
        nx_reg <= fx_mul(head_vec.x, isq_result);
        ny_reg <= fx_mul(head_vec.y, isq_result);
        nz_reg <= fx_mul(head_vec.z, isq_result);
`endif
      end
    end
  end

`ifdef VEC_NORM_ZERO_GUARD_EN
  logic zero_vec_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_vec_reg <= 1'b0;
    end else if (pop) begin
      zero_vec_reg <= head_zero;
    end
  end
  assign zero_vec = zero_vec_reg;
`else
  assign zero_vec = 1'b0;
`endif

  assign valid_out     = valid_out_reg;
  assign nx            = nx_reg;
  assign ny            = ny_reg;
  assign nz            = nz_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_vec3_normalize.sv
// Bench for vec3_normalize: behavioural inv_sqrt model, directed vectors,
// expected-response queues checked by independent monitors.
module tb_vec3_normalize;
  import vec_norm_pkg::*;

  localparam int WIDTH   = 32;
  localparam int FRAC    = 24;
  localparam int DEPTH   = 8;
  localparam int ISQ_LAT = 5;
`ifdef VEC_NORM_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_in = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] vx_in = '0;
  logic [WIDTH-1:0] vy_in = '0;
  logic [WIDTH-1:0] vz_in = '0;
  logic             isq_valid;
  logic [WIDTH-1:0] isq_x;
  logic             isq_valid_out = 1'b0;
  logic [WIDTH-1:0] isq_result = '0;
  logic             valid_out;
  logic [WIDTH-1:0] nx;
  logic [WIDTH-1:0] ny;
  logic [WIDTH-1:0] nz;
  logic             zero_vec;
  logic             err_underflow;

  always #5 clk = ~clk;

  vec3_normalize #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .DEPTH   (DEPTH),
    .ISQ_LAT (ISQ_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .in_ready      (in_ready),
    .vx_in         (vx_in),
    .vy_in         (vy_in),
    .vz_in         (vz_in),
    .isq_valid     (isq_valid),
    .isq_x         (isq_x),
    .isq_valid_out (isq_valid_out),
    .isq_result    (isq_result),
    .valid_out     (valid_out),
    .nx            (nx),
    .ny            (ny),
    .nz            (nz),
    .zero_vec      (zero_vec),
    .err_underflow (err_underflow)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int vo_count = 0;
  bit lat_chk = 1'b1;
  bit stall = 1'b0;
  int budget = 0;
  bit inject = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] nx;
    logic [31:0] ny;
    logic [31:0] nz;
    logic        zv;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    int          acc;
  } isq_exp_t;

  typedef struct {
    logic [31:0] x;
    int          due;
  } isq_req_t;

  exp_t     out_q[$];
  isq_exp_t isq_q[$];
  isq_req_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // ---------------- behavioural inv_sqrt ----------------
  function automatic logic [31:0] isq_fn(input logic [31:0] x);
    real    r;
    longint v;
    if (x == 32'h19000000) return 32'h00333333;
    if (x == 32'h0) return 32'hFFFFFFFF;
    r = $floor(68719476736.0 / $sqrt(real'(x)));
    v = longint'(r);
    if (v > 64'h00000000FFFFFFFF) return 32'hFFFFFFFF;
    return v[31:0];
  endfunction

  always @(negedge clk) begin : isq_model
    isq_req_t r;
    if (!rst) begin
      mq.delete();
      isq_valid_out = 1'b0;
      isq_result    = '0;
    end else begin
      if (isq_valid) mq.push_back(isq_req_t'{isq_x, cyc + ISQ_LAT});
      isq_valid_out = 1'b0;
      if (inject) begin
        isq_valid_out = 1'b1;
        isq_result    = 32'h01000000;
        inject        = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc && (!stall || budget > 0)) begin
        r = mq.pop_front();
        isq_valid_out = 1'b1;
        isq_result    = isq_fn(r.x);
        if (stall) budget--;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_isq
    isq_exp_t e;
    if (rst && isq_valid) begin
      if (isq_q.size() == 0) begin
        checks++;
        $display("FAIL isq_unexpected: got issue x=%h, required none", isq_x);
      end else begin
        e = isq_q.pop_front();
        chk("isq_x", isq_x, e.x);
        chk("isq_latency", cyc - e.acc, 1);
      end
    end
  end

  always @(negedge clk) begin : mon_out
    exp_t e;
    if (rst && valid_out) begin
      vo_count++;
      if (out_q.size() == 0) begin
        checks++;
        $display("FAIL out_unexpected: got valid_out nx=%h, required none", nx);
      end else begin
        e = out_q.pop_front();
        $display("out @%0d: nx=%h ny=%h nz=%h zero_vec=%b", cyc, nx, ny, nz, zero_vec);
        chk("nx", nx, e.nx);
        chk("ny", ny, e.ny);
        chk("nz", nz, e.nz);
        chk("zero_vec", {31'd0, zero_vec}, {31'd0, e.zv});
        if (e.lat) chk("out_latency", cyc - e.acc, ISQ_LAT + 2);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; the vector is offered for one cycle.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                      input logic [31:0] eisq, input bit ezv);
    valid_in = 1'b1;
    vx_in = x;
    vy_in = y;
    vz_in = z;
    if (in_ready) begin
      out_q.push_back(exp_t'{ex, ey, ez, ezv, cyc + 1, lat_chk});
      isq_q.push_back(isq_exp_t'{eisq, cyc + 1});
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((out_q.size() != 0 || isq_q.size() != 0) && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_q.size() == 0 && isq_q.size() == 0) passed++;
    else $display("FAIL drain_%s: got %0d outputs pending, required 0", tag, out_q.size());
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int vo_before;
    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_isq_valid", isq_valid, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_nx", nx, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // single vector
    send(32'h03000000, 32'h04000000, 32'h0, 32'h00999999, 32'h00CCCCCC, 32'h0, 32'h19000000, 1'b0);
    drain("single");

    // burst of six, one per cycle
    chk("burst_ready0", in_ready, 1);
    send(32'h01000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h01000000, 1'b0);
    chk("burst_ready1", in_ready, 1);
    send(32'h0, 32'h02000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h04000000, 1'b0);
    chk("burst_ready2", in_ready, 1);
    send(32'h0, 32'h0, 32'hFC000000, 32'h0, 32'h0, 32'hFF000000, 32'h10000000, 1'b0);
    chk("burst_ready3", in_ready, 1);
    send(32'h02000000, 32'h02000000, 32'h01000000, 32'h00AAAAAA, 32'h00AAAAAA, 32'h00555555, 32'h09000000, 1'b0);
    chk("burst_ready4", in_ready, 1);
    send(32'hFD000000, 32'h0, 32'h04000000, 32'hFF666667, 32'h0, 32'h00CCCCCC, 32'h19000000, 1'b0);
    chk("burst_ready5", in_ready, 1);
    send(32'h03000000, 32'h04000000, 32'h0, 32'h00999999, 32'h00CCCCCC, 32'h0, 32'h19000000, 1'b0);
    drain("burst");

    // saturation
    send(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h07F00000, 32'h07F00000, 32'h07F00000, 32'hFFFFFFFF, 1'b0);
    drain("sat");

    // zero vector between two non-zero vectors
    send(32'h01000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h01000000, 1'b0);
    send(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ZG);
    send(32'h0, 32'h02000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h04000000, 1'b0);
    drain("zero");

    // stalled inv_sqrt: fill, overflow attempt, single pops
    stall = 1'b1;
    budget = 0;
    lat_chk = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ready", in_ready, 1);
      if (i % 2 == 0)
        send(32'h01000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h01000000, 1'b0);
      else
        send(32'h0, 32'h02000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h04000000, 1'b0);
    end
    chk("full_ready", in_ready, 0);
    send(32'h0, 32'h0, 32'hFC000000, 32'h0, 32'h0, 32'hFF000000, 32'h10000000, 1'b0);
    chk("full_drop_ready", in_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("full_still_ready", in_ready, 0);
    budget = 1;
    @(posedge clk);
    #1;
    chk("pop_reopens_ready", in_ready, 1);
    budget = 1;
    send(32'h02000000, 32'h02000000, 32'h01000000, 32'h00AAAAAA, 32'h00AAAAAA, 32'h00555555, 32'h09000000, 1'b0);
    chk("pop_accept_ready", in_ready, 1);
    send(32'h03000000, 32'h04000000, 32'h0, 32'h00999999, 32'h00CCCCCC, 32'h0, 32'h19000000, 1'b0);
    chk("refill_ready", in_ready, 0);
    stall = 1'b0;
    drain("stall");
    lat_chk = 1'b1;

    // reset with three vectors pending
    send(32'h01000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h01000000, 1'b0);
    send(32'h0, 32'h02000000, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'h04000000, 1'b0);
    send(32'h03000000, 32'h04000000, 32'h0, 32'h00999999, 32'h00CCCCCC, 32'h0, 32'h19000000, 1'b0);
    #2 rst = 1'b0;
    #1;
    out_q.delete();
    isq_q.delete();
    chk("arst_in_ready", in_ready, 1);
    chk("arst_valid_out", valid_out, 0);
    chk("arst_isq_valid", isq_valid, 0);
    chk("arst_nx", nx, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    vo_before = vo_count;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_no_output", vo_count - vo_before, 0);
    chk("arst_err_clear", err_underflow, 0);

    // spurious inv_sqrt result
    inject = 1'b1;
    @(posedge clk);
    #1;
    chk("underflow_set", err_underflow, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("underflow_sticky", err_underflow, 1);
    chk("underflow_no_output", vo_count - vo_before, 0);
    chk("underflow_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
